eeprom_master: RTL

- Hardware I2C-style bus controller that initiates single-byte random write and random read transactions to the cartridge 24C64-class serial EEPROM.
- Used by the save-state/backup path and by the EEPROM responder testbench.
- Accepts one command at a time on a valid/ready interface and generates SCL/SDA with open-drain semantics.
- Returns read data and an ACK/NACK status on a one-cycle response strobe.

---
 rtl/eeprom_master_if.sv | 25 ++
 rtl/eeprom_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_master_if.sv
// Command/response handshake and open-drain bus lines of the serial EEPROM master.
// The master modport belongs to the controller; the slave modport belongs to its client.
interface eeprom_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rw;
   logic [12:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_nack;
   logic        scl;
   logic        sda_out;
   logic        sda_in;

   modport master (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, sda_in,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, scl, sda_out
   );

   modport slave (
      output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, sda_in,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, scl, sda_out
   );
endinterface

// File: rtl/eeprom_master.sv
// Single-byte random write / random read master for a 24C64-class serial EEPROM.
// Each bus symbol is four phases of CLK_DIV cycles; all outputs are registered.
module eeprom_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic            clk,
   input  logic            reset,
   eeprom_master_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_TX_BYTE, S_TX_ACK, S_RESTART,
      S_RX_BYTE, S_RX_NACK, S_STOP, S_DONE
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   // Returns {scl, sda} for a symbol phase; bit states carry the data bit on SDA.
   function automatic logic [1:0] line_levels(input state_t st, input logic [1:0] p, input logic b);
      logic [1:0] lv;
      case (st)
         S_START, S_RESTART: begin
            case (p)
               2'd0:    lv = 2'b01;
               2'd1:    lv = 2'b11;
               2'd2:    lv = 2'b10;
               default: lv = 2'b00;
            endcase
         end
         S_TX_BYTE, S_TX_ACK, S_RX_BYTE, S_RX_NACK: lv = {p[1], b};
         S_STOP: begin
            case (p)
               2'd0:    lv = 2'b00;
               2'd1:    lv = 2'b10;
               default: lv = 2'b11;
            endcase
         end
         default: lv = 2'b11;
      endcase
      return lv;
   endfunction

   // Byte slot 3 is the write data, or the read device address after the repeated start.
   function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic rw,
                                          input logic [12:0] addr, input logic [7:0] wdata);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'hA0;
         3'd1:    b = {3'b000, addr[12:8]};
         3'd2:    b = addr[7:0];
         3'd3:    b = rw ? 8'hA1 : wdata;
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  ph_cnt_q, ph_cnt_d;
   logic [1:0]  p_q, p_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic        rw_q, rw_d;
   logic [12:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rx_q, rx_d;
   logic        samp_q, samp_d;
   logic        nack_q, nack_d;
   logic        scl_q, scl_d;
   logic        sda_q, sda_d;
   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic        rsp_nack_q, rsp_nack_d;

   logic        accept_s;
   logic        last_cyc_s;
   logic        sym_end_s;
   logic        in_bit_s;
   logic [7:0]  txb_s;
   logic        bit_val_s;

   // Next-state, phase timing, bit sampling and registered-output decode.
   always_comb begin
      state_d     = state_q;
      ph_cnt_d    = ph_cnt_q;
      p_d         = p_q;
      bit_idx_d   = bit_idx_q;
      byte_idx_d  = byte_idx_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rx_d        = rx_q;
      samp_d      = samp_q;
      nack_d      = nack_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_nack_d  = rsp_nack_q;

      accept_s   = bus.cmd_valid && ready_q;
      last_cyc_s = (ph_cnt_q == DIV_LAST);
      sym_end_s  = last_cyc_s && (p_q == 2'd3);
      in_bit_s   = (state_q == S_TX_BYTE) || (state_q == S_TX_ACK) ||
                   (state_q == S_RX_BYTE) || (state_q == S_RX_NACK);

      if (state_q != S_IDLE && state_q != S_DONE) begin
         if (last_cyc_s) begin
            ph_cnt_d = 8'd0;
            p_d      = 2'(p_q + 2'd1);
         end else begin
            ph_cnt_d = 8'(ph_cnt_q + 8'd1);
         end
      end else begin
         ph_cnt_d = 8'd0;
         p_d      = 2'd0;
      end

      // SDA is sampled on the last cycle of the SCL-high phase p2.
      if (in_bit_s && last_cyc_s && (p_q == 2'd2)) begin
         samp_d = bus.sda_in;
         if (state_q == S_RX_BYTE) begin
            rx_d = {rx_q[6:0], bus.sda_in};
         end else begin
            rx_d = rx_q;
         end
      end else begin
         samp_d = samp_q;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               state_d    = S_START;
               bit_idx_d  = 4'd0;
               byte_idx_d = 3'd0;
               rw_d       = bus.cmd_rw;
               addr_d     = bus.cmd_addr;
               wdata_d    = bus.cmd_wdata;
               rx_d       = 8'h00;
               nack_d     = 1'b0;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START, S_RESTART: begin
            if (sym_end_s) begin
               state_d   = S_TX_BYTE;
               bit_idx_d = 4'd0;
            end else begin
               state_d = state_q;
            end
         end
         S_TX_BYTE, S_RX_BYTE: begin
            if (sym_end_s && bit_idx_q == 4'd7) begin
               state_d   = (state_q == S_TX_BYTE) ? S_TX_ACK : S_RX_NACK;
               bit_idx_d = 4'd8;
            end else if (sym_end_s) begin
               bit_idx_d = 4'(bit_idx_q + 4'd1);
            end else begin
               bit_idx_d = bit_idx_q;
            end
         end
         S_TX_ACK: begin
            if (sym_end_s) begin
               if (samp_q) begin
                  nack_d  = 1'b1;
                  state_d = S_STOP;
               end else if (byte_idx_q == 3'd3) begin
                  state_d   = rw_q ? S_RX_BYTE : S_STOP;
                  bit_idx_d = 4'd0;
               end else if (byte_idx_q == 3'd2 && rw_q) begin
                  state_d    = S_RESTART;
                  byte_idx_d = 3'd3;
               end else begin
                  state_d    = S_TX_BYTE;
                  byte_idx_d = 3'(byte_idx_q + 3'd1);
                  bit_idx_d  = 4'd0;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_RX_NACK: begin
            if (sym_end_s) begin
               state_d = S_STOP;
            end else begin
               state_d = state_q;
            end
         end
         S_STOP: begin
            if (sym_end_s) begin
               state_d     = S_DONE;
               rsp_valid_d = 1'b1;
               rsp_nack_d  = nack_q;
               rsp_rdata_d = (rw_q && !nack_q) ? rx_q : 8'h00;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      txb_s     = tx_byte(byte_idx_d, rw_q, addr_q, wdata_q);
      bit_val_s = (state_d == S_TX_BYTE) ? txb_s[3'd7 - bit_idx_d[2:0]] : 1'b1;
      {scl_d, sda_d} = line_levels(state_d, p_d, bit_val_s);
      ready_d   = (state_d == S_IDLE) || (state_d == S_DONE);
   end

   // State and output registers; reset returns the bus to idle immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ph_cnt_q    <= 8'd0;
         p_q         <= 2'd0;
         bit_idx_q   <= 4'd0;
         byte_idx_q  <= 3'd0;
         rw_q        <= 1'b0;
         addr_q      <= 13'd0;
         wdata_q     <= 8'h00;
         rx_q        <= 8'h00;
         samp_q      <= 1'b0;
         nack_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_nack_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_cnt_q    <= ph_cnt_d;
         p_q         <= p_d;
         bit_idx_q   <= bit_idx_d;
         byte_idx_q  <= byte_idx_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rx_q        <= rx_d;
         samp_q      <= samp_d;
         nack_q      <= nack_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_nack_q  <= rsp_nack_d;
      end
   end

   assign bus.scl       = scl_q;
   assign bus.sda_out   = sda_q;
   assign bus.cmd_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_nack  = rsp_nack_q;

endmodule
